csr_access_unit: RTL and testbench
==================================

// Module: csr_access_unit
// PURPOSE
//  Initiator side of the CSR read/write port: executes Zicsr instructions (CSRRW/S/C and
//  immediate forms) against the CSR file. Accepts one decoded request from EXE with a
//  valid/ready handshake, then drives a read cycle and a write cycle on the CSR port.
//  Returns the old CSR value to writeback with a second valid/ready handshake.
//  Sits between the EXE stage and the csrfile; at most one access is in flight.
// PARAMETERS
//  XLEN    64  datapath width (matches `REG_BUS)
//  ADDR_W  12  CSR address width
// PORTS
//  clk           in   1       clock
//  rst           in   1       reset, synchronous, active-high
//  req_valid     in   1       EXE presents a CSR request
//  req_ready     out  1       unit idle, can accept
//  req_funct3    in   3       Zicsr funct3: 001 RW, 010 RS, 011 RC, 101 RWI, 110 RSI, 111 RCI
//  req_addr      in   ADDR_W  CSR address (inst[31:20])
//  req_rs1_idx   in   5       rs1 index, or uimm[4:0] for immediate forms
//  req_rs1_data  in   XLEN    rs1 value (ignored for immediate forms)
//  req_rd_idx    in   5       destination register index
//  csr_rd_ena    out  1       CSR read strobe
//  csr_rd_addr   out  ADDR_W  CSR read address
//  csr_rd_data   in   XLEN    CSR read data, combinational from addr/ena
//  csr_wr_ena    out  1       CSR write strobe, committed by csrfile at posedge
//  csr_wr_addr   out  ADDR_W  CSR write address
//  csr_wr_data   out  XLEN    CSR write data
//  resp_valid    out  1       result available
//  resp_ready    in   1       WB accepts result
//  resp_data     out  XLEN    old CSR value (to be written to rd)
//  resp_rd_idx   out  5       rd index
//  resp_illegal  out  1       illegal-instruction indication
// BEHAVIOUR
//  Reset: state=IDLE; req_ready=1; csr_rd_ena=0; csr_wr_ena=0; resp_valid=0; all data outs 0.
//  FSM IDLE -> READ -> WRITE -> RESP -> IDLE. req_ready = (state==IDLE).
//  IDLE: on req_valid, latch funct3/addr/rs1_idx/rs1_data/rd_idx; go READ.
//  READ (1 cycle): csr_rd_addr=addr_q; csr_rd_ena=1 unless (RW/RWI and rd_q==0);
//    capture old_q = rd_ena ? csr_rd_data : 0; compute new_q; go WRITE.
//  Operand: reg forms rs1_data_q; imm forms {XLEN-5 zeros, rs1_idx_q}.
//  new value: RW/RWI op; RS/RSI old|op; RC/RCI old&~op.
//  do_write: RW/RWI always; RS/RC/RSI/RCI only when rs1_idx_q != 0.
//  illegal: funct3 in {000,100}, or (do_write and addr_q[11:10]==2'b11, read-only CSR).
//  WRITE (1 cycle): csr_wr_ena = do_write & ~illegal; csr_wr_addr=addr_q; csr_wr_data=new_q.
//    Write strobes are exactly one cycle; addr/data held 0 when strobe low. Go RESP.
//  RESP: resp_valid=1, resp_data=old_q, resp_rd_idx=rd_q, resp_illegal=illegal_q; stable
//    until resp_ready; on resp_valid&resp_ready go IDLE (next request accepted next cycle).
//  Latency: accept at edge N; read N+1; write N+2; resp_valid from cycle N+3. Throughput 1/4.
//  Read-modify-write uses the value sampled in READ; free-running counters (mcycle) that
//    advance between READ and WRITE are overwritten by new_q (write wins, csrfile rule).
//  Illegal request: no CSR write issued; resp_data = old_q; WB must suppress rd on illegal.
//  rst in any state: return to IDLE next edge, drop in-flight request, no write issued.
// STRUCTURE
//  defines.v: `CSR_F3_RW/RS/RC/RWI/RSI/RCI localparams, `CSR_ADDR_BUS width macro.
//  One sub-module: csr_alu (combinational: funct3, old, operand, rs1_idx -> new, do_write,
//    illegal). FSM, latches and handshakes stay in csr_access_unit.
// TESTING
//  CSRRS x5, mcycle, x0 -> rd_ena=1 addr 0xB00, wr_ena never 1, resp_data=mcycle sample.
//  CSRRW x0, mcycle, x6=0x100 -> rd_ena=0, one-cycle wr_ena, wr_data=0x100, resp_data=0.
//  CSRRCI x7, mcycle, 0x1F with mcycle=0x3F -> wr_data=0x20 at WRITE, resp_data=0x3F.
//  CSRRW to 0xF11 (mvendorid) -> resp_illegal=1, wr_ena stays 0, resp_data=0.
//  resp_ready held 0 for 5 cycles -> resp_valid/data stable, req_ready=0 throughout.
//  rst asserted during WRITE state -> wr_ena=0 next cycle, req_ready=1, no resp_valid.

Source files
------------

// File: rtl/csr_access_unit_pkg.sv
// rtl/csr_access_unit_pkg.sv - shared widths, Zicsr funct3 codes and FSM states for the CSR access unit
package csr_access_unit_pkg;

    localparam int CSR_XLEN   = 64;
    localparam int CSR_ADDR_W = 12;

    localparam logic [2:0] CSR_F3_RW  = 3'b001;
    localparam logic [2:0] CSR_F3_RS  = 3'b010;
    localparam logic [2:0] CSR_F3_RC  = 3'b011;
    localparam logic [2:0] CSR_F3_RWI = 3'b101;
    localparam logic [2:0] CSR_F3_RSI = 3'b110;
    localparam logic [2:0] CSR_F3_RCI = 3'b111;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_READ,
        ST_WRITE,
        ST_RESP
    } csr_state_e;

    // funct3[2] selects the uimm operand; funct3[1:0]==01 is a plain swap
    function automatic logic f3_is_imm(input logic [2:0] f3);
        return f3[2];
    endfunction

    function automatic logic f3_is_swap(input logic [2:0] f3);
        return f3[1:0] == 2'b01;
    endfunction

endpackage

// File: rtl/csr_access_unit_if.sv
// rtl/csr_access_unit_if.sv - request, CSR port and response signals of the CSR access unit
interface csr_access_unit_if
    import csr_access_unit_pkg::*;
#(
    parameter int XLEN   = CSR_XLEN,
    parameter int ADDR_W = CSR_ADDR_W
);
    logic              req_valid;
    logic              req_ready;
    logic [2:0]        req_funct3;
    logic [ADDR_W-1:0] req_addr;
    logic [4:0]        req_rs1_idx;
    logic [XLEN-1:0]   req_rs1_data;
    logic [4:0]        req_rd_idx;

    logic              csr_rd_ena;
    logic [ADDR_W-1:0] csr_rd_addr;
    logic [XLEN-1:0]   csr_rd_data;
    logic              csr_wr_ena;
    logic [ADDR_W-1:0] csr_wr_addr;
    logic [XLEN-1:0]   csr_wr_data;

    logic              resp_valid;
    logic              resp_ready;
    logic [XLEN-1:0]   resp_data;
    logic [4:0]        resp_rd_idx;
    logic              resp_illegal;

    modport master (
        input  req_valid, req_funct3, req_addr, req_rs1_idx, req_rs1_data, req_rd_idx,
        input  csr_rd_data, resp_ready,
        output req_ready, csr_rd_ena, csr_rd_addr, csr_wr_ena, csr_wr_addr, csr_wr_data,
        output resp_valid, resp_data, resp_rd_idx, resp_illegal
    );

    modport slave (
        output req_valid, req_funct3, req_addr, req_rs1_idx, req_rs1_data, req_rd_idx,
        output csr_rd_data, resp_ready,
        input  req_ready, csr_rd_ena, csr_rd_addr, csr_wr_ena, csr_wr_addr, csr_wr_data,
        input  resp_valid, resp_data, resp_rd_idx, resp_illegal
    );

endinterface

// File: rtl/csr_access_unit_alu.sv
// rtl/csr_access_unit_alu.sv - combinational Zicsr new-value, write-enable and legality decode
module csr_access_unit_alu
    import csr_access_unit_pkg::*;
#(
    parameter int XLEN = CSR_XLEN
)
(
    input  logic [2:0]      funct3_i,
    input  logic [XLEN-1:0] old_i,
    input  logic [XLEN-1:0] operand_i,
    input  logic [4:0]      rs1_idx_i,
    input  logic            addr_ro_i,
    output logic [XLEN-1:0] new_o,
    output logic            do_write_o,
    output logic            illegal_o
);

    logic f3_ok;

    always_comb begin
        new_o      = '0;
        do_write_o = 1'b0;
        f3_ok      = 1'b1;
        // set/clear with rs1=x0 (or uimm=0) are pure reads and must not touch the CSR
        case (funct3_i[1:0])
            2'b01: begin
                new_o      = operand_i;
                do_write_o = 1'b1;
            end
            2'b10: begin
                new_o      = old_i | operand_i;
                do_write_o = rs1_idx_i != 5'd0;
            end
            2'b11: begin
                new_o      = old_i & ~operand_i;
                do_write_o = rs1_idx_i != 5'd0;
            end
            default: f3_ok = 1'b0;
        endcase
        illegal_o = !f3_ok || (do_write_o && addr_ro_i);
    end

endmodule

// File: rtl/csr_access_unit.sv
// rtl/csr_access_unit.sv - Zicsr initiator: accept request, read CSR, write CSR, return old value
module csr_access_unit
    import csr_access_unit_pkg::*;
#(
    parameter int XLEN   = CSR_XLEN,
    parameter int ADDR_W = CSR_ADDR_W
)
(
    input  logic             clk,
    input  logic             rst,
    csr_access_unit_if.master bus
);

    csr_state_e        state_q, state_d;
    logic [2:0]        funct3_q;
    logic [ADDR_W-1:0] addr_q;
    logic [4:0]        rs1_idx_q;
    logic [XLEN-1:0]   rs1_data_q;
    logic [4:0]        rd_q;
    logic [XLEN-1:0]   old_q;
    logic [XLEN-1:0]   new_q;
    logic              do_write_q;
    logic              illegal_q;

    logic              rd_ena;
    logic              wr_ena;
    logic [XLEN-1:0]   old_d;
    logic [XLEN-1:0]   operand;
    logic [XLEN-1:0]   alu_new;
    logic              alu_do_write;
    logic              alu_illegal;

    assign operand = f3_is_imm(funct3_q) ? {{(XLEN-5){1'b0}}, rs1_idx_q} : rs1_data_q;
    assign old_d   = rd_ena ? bus.csr_rd_data : '0;

    csr_access_unit_alu #(.XLEN(XLEN)) u_alu (
        .funct3_i   (funct3_q),
        .old_i      (old_d),
        .operand_i  (operand),
        .rs1_idx_i  (rs1_idx_q),
        .addr_ro_i  (addr_q[ADDR_W-1 -: 2] == 2'b11),
        .new_o      (alu_new),
        .do_write_o (alu_do_write),
        .illegal_o  (alu_illegal)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            funct3_q   <= '0;
            addr_q     <= '0;
            rs1_idx_q  <= '0;
            rs1_data_q <= '0;
            rd_q       <= '0;
            old_q      <= '0;
            new_q      <= '0;
            do_write_q <= 1'b0;
            illegal_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            if (state_q == ST_IDLE && bus.req_valid) begin
                funct3_q   <= bus.req_funct3;
                addr_q     <= bus.req_addr;
                rs1_idx_q  <= bus.req_rs1_idx;
                rs1_data_q <= bus.req_rs1_data;
                rd_q       <= bus.req_rd_idx;
            end
            if (state_q == ST_READ) begin
                old_q      <= old_d;
                new_q      <= alu_new;
                do_write_q <= alu_do_write;
                illegal_q  <= alu_illegal;
            end
        end
    end

    always_comb begin
        state_d          = state_q;
        rd_ena           = 1'b0;
        wr_ena           = 1'b0;
        bus.req_ready    = 1'b0;
        bus.resp_valid   = 1'b0;
        bus.resp_data    = '0;
        bus.resp_rd_idx  = '0;
        bus.resp_illegal = 1'b0;
        case (state_q)
            ST_IDLE: begin
                bus.req_ready = 1'b1;
                if (bus.req_valid) state_d = ST_READ;
            end
            ST_READ: begin
                // a swap into x0 has no architectural read, so skip read side effects
                rd_ena  = !(f3_is_swap(funct3_q) && rd_q == 5'd0);
                state_d = ST_WRITE;
            end
            ST_WRITE: begin
                wr_ena  = do_write_q && !illegal_q && !rst;
                state_d = ST_RESP;
            end
            ST_RESP: begin
                bus.resp_valid   = 1'b1;
                bus.resp_data    = old_q;
                bus.resp_rd_idx  = rd_q;
                bus.resp_illegal = illegal_q;
                if (bus.resp_ready) state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    assign bus.csr_rd_ena  = rd_ena;
    assign bus.csr_rd_addr = rd_ena ? addr_q : '0;
    assign bus.csr_wr_ena  = wr_ena;
    assign bus.csr_wr_addr = wr_ena ? addr_q : '0;
    assign bus.csr_wr_data = wr_ena ? new_q : '0;

endmodule

// File: tb/tb_csr_access_unit.sv
// tb/tb_csr_access_unit.sv - directed and randomized bench for csr_access_unit with a csrfile model
module tb_csr_access_unit;
    import csr_access_unit_pkg::*;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    csr_access_unit_if bus ();

    csr_access_unit dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    // csrfile model: mcycle at 0xB00 free-runs, a CSR write in the same cycle wins
    bit   [63:0] mem [0:4095];
    logic        mc_run  = 1'b1;
    logic        ld_en   = 1'b0;
    logic [11:0] ld_addr = '0;
    logic [63:0] ld_val  = '0;
    int          wr_cnt  = 0;

    assign bus.csr_rd_data = bus.csr_rd_ena ? mem[bus.csr_rd_addr] : 64'h0;

    always @(posedge clk) begin
        if (mc_run) mem[12'hB00] <= mem[12'hB00] + 64'd1;
        if (ld_en) mem[ld_addr] <= ld_val;
        if (bus.csr_wr_ena) begin
            mem[bus.csr_wr_addr] <= bus.csr_wr_data;
            wr_cnt <= wr_cnt + 1;
        end
    end

    int checks = 0;
    int errors = 0;

    logic [63:0] last_resp;
    logic [63:0] last_wr;
    logic        last_ill;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic void ref_model(input logic [2:0] f3, input logic [11:0] addr,
                                      input logic [4:0] rs1, input logic [63:0] rs1d,
                                      input logic [63:0] old, output logic [63:0] nv,
                                      output bit dw, output bit ill);
        logic [63:0] op;
        op  = (f3 >= 3'd4) ? 64'(rs1) : rs1d;
        nv  = 64'h0;
        dw  = 1'b0;
        ill = 1'b0;
        if (f3 == 3'd0 || f3 == 3'd4) ill = 1'b1;
        else if (f3 == 3'd1 || f3 == 3'd5) begin
            nv = op;
            dw = 1'b1;
        end else if (f3 == 3'd2 || f3 == 3'd6) begin
            nv = old | op;
            dw = (rs1 != 0);
        end else begin
            nv = old & ~op;
            dw = (rs1 != 0);
        end
        if (dw && addr[11:10] == 2'b11) ill = 1'b1;
    endfunction

    task automatic load(input logic [11:0] a, input logic [63:0] v);
        @(negedge clk);
        ld_en   = 1'b1;
        ld_addr = a;
        ld_val  = v;
        @(negedge clk);
        ld_en   = 1'b0;
    endtask

    task automatic run_req(input logic [2:0] f3, input logic [11:0] addr, input logic [4:0] rs1,
                           input logic [63:0] rs1d, input logic [4:0] rd, input int hold);
        bit          exp_rd, dw, ill, exp_we;
        logic [63:0] old, nv;
        int          w0;
        @(negedge clk);
        check("req_ready_idle", bus.req_ready, 1);
        bus.req_valid    = 1'b1;
        bus.req_funct3   = f3;
        bus.req_addr     = addr;
        bus.req_rs1_idx  = rs1;
        bus.req_rs1_data = rs1d;
        bus.req_rd_idx   = rd;
        @(negedge clk);
        bus.req_valid    = 1'b0;
        bus.req_funct3   = 3'($urandom);
        bus.req_addr     = 12'($urandom);
        bus.req_rs1_idx  = 5'($urandom);
        bus.req_rs1_data = {$urandom, $urandom};
        bus.req_rd_idx   = 5'($urandom);
        exp_rd = !((f3 == 3'd1 || f3 == 3'd5) && rd == 0);
        check("read_ena", bus.csr_rd_ena, exp_rd);
        check("read_addr", bus.csr_rd_addr, exp_rd ? addr : 12'h0);
        check("req_ready_busy", bus.req_ready, 0);
        old = exp_rd ? mem[addr] : 64'h0;
        ref_model(f3, addr, rs1, rs1d, old, nv, dw, ill);
        exp_we = dw && !ill;
        w0 = wr_cnt;
        @(negedge clk);
        check("write_ena", bus.csr_wr_ena, exp_we);
        check("write_addr", bus.csr_wr_addr, exp_we ? addr : 12'h0);
        check("write_data", bus.csr_wr_data, exp_we ? nv : 64'h0);
        check("read_ena_in_write", bus.csr_rd_ena, 0);
        @(negedge clk);
        check("write_count", 64'(wr_cnt - w0), 64'(exp_we));
        check("resp_valid", bus.resp_valid, 1);
        check("resp_data", bus.resp_data, old);
        check("resp_rd_idx", bus.resp_rd_idx, rd);
        check("resp_illegal", bus.resp_illegal, ill);
        for (int i = 0; i < hold; i++) begin
            @(negedge clk);
            check("hold_valid", bus.resp_valid, 1);
            check("hold_data", bus.resp_data, old);
            check("hold_req_ready", bus.req_ready, 0);
        end
        bus.resp_ready = 1'b1;
        @(negedge clk);
        bus.resp_ready = 1'b0;
        check("resp_done_valid", bus.resp_valid, 0);
        check("resp_done_ready", bus.req_ready, 1);
        last_resp = old;
        last_wr   = nv;
        last_ill  = ill;
    endtask

    initial begin
        logic [11:0] addrs [8];
        addrs = '{12'h300, 12'h340, 12'h305, 12'hB00, 12'hC00, 12'hF11, 12'h7C0, 12'h001};
        bus.req_valid    = 1'b0;
        bus.req_funct3   = '0;
        bus.req_addr     = '0;
        bus.req_rs1_idx  = '0;
        bus.req_rs1_data = '0;
        bus.req_rd_idx   = '0;
        bus.resp_ready   = 1'b0;

        repeat (3) @(negedge clk);
        check("rst_req_ready", bus.req_ready, 1);
        check("rst_rd_ena", bus.csr_rd_ena, 0);
        check("rst_rd_addr", bus.csr_rd_addr, 0);
        check("rst_wr_ena", bus.csr_wr_ena, 0);
        check("rst_wr_addr", bus.csr_wr_addr, 0);
        check("rst_wr_data", bus.csr_wr_data, 0);
        check("rst_resp_valid", bus.resp_valid, 0);
        check("rst_resp_data", bus.resp_data, 0);
        check("rst_resp_rd", bus.resp_rd_idx, 0);
        check("rst_resp_illegal", bus.resp_illegal, 0);
        rst = 1'b0;

        for (int i = 0; i < 8; i++)
            if (addrs[i] != 12'hB00) load(addrs[i], {$urandom, $urandom});

        // CSRRS x5, mcycle, x0
        run_req(3'b010, 12'hB00, 5'd0, {$urandom, $urandom}, 5'd5, 0);
        // CSRRW x0, mcycle, x6=0x100
        run_req(3'b001, 12'hB00, 5'd6, 64'h100, 5'd0, 0);
        check("rw_x0_resp", last_resp, 64'h0);
        check("rw_x0_wdata", last_wr, 64'h100);
        // CSRRCI x7, mcycle, 0x1F with mcycle frozen at 0x3F
        mc_run = 1'b0;
        load(12'hB00, 64'h3F);
        run_req(3'b111, 12'hB00, 5'h1F, {$urandom, $urandom}, 5'd7, 0);
        check("rrci_wdata", last_wr, 64'h20);
        check("rrci_resp", last_resp, 64'h3F);
        mc_run = 1'b1;
        // CSRRW x0, mvendorid, x9 is illegal (read-only space)
        run_req(3'b001, 12'hF11, 5'd9, {$urandom, $urandom}, 5'd0, 0);
        check("ro_illegal", last_ill, 1);
        check("ro_resp", last_resp, 64'h0);
        // back-pressure on the response
        run_req(3'b010, 12'h300, 5'd3, {$urandom, $urandom}, 5'd4, 5);

        // reset while in WRITE
        begin
            int w0;
            @(negedge clk);
            bus.req_valid    = 1'b1;
            bus.req_funct3   = 3'b001;
            bus.req_addr     = 12'h340;
            bus.req_rs1_idx  = 5'd1;
            bus.req_rs1_data = {$urandom, $urandom};
            bus.req_rd_idx   = 5'd2;
            @(negedge clk);
            bus.req_valid = 1'b0;
            @(negedge clk);
            w0  = wr_cnt;
            rst = 1'b1;
            #1;
            check("rstw_wr_ena_now", bus.csr_wr_ena, 0);
            @(negedge clk);
            check("rstw_wr_ena", bus.csr_wr_ena, 0);
            check("rstw_req_ready", bus.req_ready, 1);
            check("rstw_resp_valid", bus.resp_valid, 0);
            rst = 1'b0;
            @(negedge clk);
            check("rstw_no_write", 64'(wr_cnt - w0), 64'h0);
            check("rstw_resp_after", bus.resp_valid, 0);
        end

        for (int n = 0; n < 40; n++) begin
            logic [4:0] rs1, rd;
            rs1 = ($urandom_range(0, 2) == 0) ? 5'd0 : 5'($urandom);
            rd  = ($urandom_range(0, 2) == 0) ? 5'd0 : 5'($urandom);
            run_req(3'($urandom_range(0, 7)), addrs[$urandom_range(0, 7)], rs1,
                    {$urandom, $urandom}, rd, $urandom_range(0, 3));
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
